debug_step_ctrl: RTL and testbench

//   Board-side debug input path for the CPU. It is the counterpart of the LED PC-monitor output.
//   - Takes raw pushbuttons and switches.
//   - Produces a single clock-enable, cpuClkEn, that gates every CPU state update.
//   - Supports halt, single-step, free-run and a coarse PC breakpoint (PC[31:16] match).

---
 rtl/debug_step_ctrl_pkg.sv | 22 ++
 rtl/debug_step_ctrl_debounce.sv | 66 ++++++
 rtl/debug_step_ctrl.sv | 111 +++++++++++
 tb/tb_debug_step_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_step_ctrl_pkg.sv
// Shared definitions for the debug step controller: FSM state encoding and defaults.
package debug_step_ctrl_pkg;

    // Default number of consecutive stable cycles before a button level is accepted.
    localparam int unsigned DebounceCyclesDefault = 500000;

    // Default width of the coarse PC breakpoint compare (upper PC bits).
    localparam int unsigned BpBitsDefault = 16;

    // Run-control FSM states; encoding 2'd3 is illegal and recovers to StHalt.
    typedef enum logic [1:0] {
        StHalt = 2'd0,
        StStep = 2'd1,
        StRun  = 2'd2
    } dbg_state_e;

    // Width of a counter that must reach cycles-1; one spare bit keeps the compare simple.
    function automatic int unsigned debounce_cnt_width(int unsigned cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/debug_step_ctrl_debounce.sv
// Button conditioning: 2-FF synchroniser, stability counter, and a one-cycle pulse on
// each accepted rising edge of the debounced level.
module debug_step_ctrl_debounce
    import debug_step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
    input  logic sysClk,
    input  logic sysRes,
    input  logic btnRaw,
    output logic pulse
);

    localparam int unsigned CntW = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      syncQ;
    logic            synced;
    logic [CntW-1:0] cntQ, cntD;
    logic            levelQ, levelD;
    logic            levelPrevQ;

    assign synced = syncQ[1];

    // Two-stage synchroniser for the asynchronous button pin.
    always_ff @(posedge sysClk or posedge sysRes) begin
        if (sysRes) begin
            syncQ <= 2'b00;
        end else begin
            syncQ <= {syncQ[0], btnRaw};
        end
    end

    // Count consecutive cycles the synced input disagrees with the accepted level.
    always_comb begin
        cntD   = cntQ;
        levelD = levelQ;
        if (synced == levelQ) begin
            cntD = '0;
        end else if (cntQ == CntMax) begin
            levelD = synced;
            cntD   = '0;
        end else begin
            cntD = cntQ + CntW'(1);
        end
    end

    // Counter, debounced level and its one-cycle-delayed copy for edge detection.
    always_ff @(posedge sysClk or posedge sysRes) begin
        if (sysRes) begin
            cntQ       <= '0;
            levelQ     <= 1'b0;
            levelPrevQ <= 1'b0;
        end else begin
            cntQ       <= cntD;
            levelQ     <= levelD;
            levelPrevQ <= levelQ;
        end
    end

    // Press accepted: single-cycle pulse; release produces nothing.
    always_comb begin
        pulse = levelQ & ~levelPrevQ;
    end

endmodule

// File: rtl/debug_step_ctrl.sv
// Board-side run control for the CPU: debounced step and run/halt buttons plus a coarse
// upper-PC breakpoint, producing the clock enable that gates every CPU state update.
module debug_step_ctrl
    import debug_step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
    parameter int unsigned BP_BITS         = BpBitsDefault
) (
    input  logic               sysClk,
    input  logic               sysRes,
    input  logic               btnStep,
    input  logic               btnRun,
    input  logic               bpEnable,
    input  logic [BP_BITS-1:0] bpAddr,
    input  logic [31:0]        pc,
    output logic               cpuClkEn,
    output logic               halted,
    output logic               bpHit
);

    dbg_state_e stateQ, stateD;
    logic       stepP, runP;
    logic       match, matchPrevQ, hitNow;
    logic       bpHitQ, bpHitD;
    logic       unusedPcLow;

    // Only the upper PC bits take part in the breakpoint compare.
    assign unusedPcLow = ^pc[31-BP_BITS:0];

    debug_step_ctrl_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .sysClk (sysClk),
        .sysRes (sysRes),
        .btnRaw (btnStep),
        .pulse  (stepP)
    );

    debug_step_ctrl_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_run_db (
        .sysClk (sysClk),
        .sysRes (sysRes),
        .btnRaw (btnRun),
        .pulse  (runP)
    );

    // Breakpoint fires only on entry into the matching region, so resuming inside it is quiet.
    always_comb begin
        match  = bpEnable && (pc[31 -: BP_BITS] == bpAddr);
        hitNow = match && !matchPrevQ;
    end

    // Previous-cycle match tracks in every state, including while halted.
    always_ff @(posedge sysClk or posedge sysRes) begin
        if (sysRes) begin
            matchPrevQ <= 1'b0;
        end else begin
            matchPrevQ <= match;
        end
    end

    // FSM state and sticky breakpoint flag registers.
    always_ff @(posedge sysClk or posedge sysRes) begin
        if (sysRes) begin
            stateQ <= StHalt;
            bpHitQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            bpHitQ <= bpHitD;
        end
    end

    // Next-state: run beats step in HALT; a hit in RUN always records bpHit.
    always_comb begin
        stateD = stateQ;
        bpHitD = bpHitQ;
        case (stateQ)
            StHalt: begin
                if (runP) begin
                    stateD = StRun;
                    bpHitD = 1'b0;
                end else if (stepP) begin
                    stateD = StStep;
                end
            end
            StStep: begin
                stateD = StHalt;
            end
            StRun: begin
                if (hitNow) begin
                    stateD = StHalt;
                    bpHitD = 1'b1;
                end else if (runP) begin
                    stateD = StHalt;
                end
            end
            default: begin
                stateD = StHalt;
            end
        endcase
    end

    // Outputs: the instruction at a freshly matched PC is held back (no enable in hit cycle).
    always_comb begin
        cpuClkEn = (stateQ == StStep) || ((stateQ == StRun) && !hitNow);
        halted   = (stateQ == StHalt);
        bpHit    = bpHitQ;
    end

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Self-checking bench for debug_step_ctrl with a short debounce window.
module tb_debug_step_ctrl;

    localparam int unsigned DB  = 4;
    localparam int unsigned BPB = 16;
    localparam int MHalt = 0;
    localparam int MStep = 1;
    localparam int MRun  = 2;

    logic           sysClk = 1'b0;
    logic           sysRes;
    logic           btnStep;
    logic           btnRun;
    logic           bpEnable;
    logic [BPB-1:0] bpAddr;
    logic [31:0]    pc;
    logic           cpuClkEn;
    logic           halted;
    logic           bpHit;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: raw button sample history, accepted levels, pending pulses, run mode.
    bit hS [0:DB+1];
    bit hR [0:DB+1];
    bit lvlS, lvlR, pStep, pRun;
    int mMode;
    bit mBpHit, mMatchPrev, mMatch;
    bit expEn, expHalt, expBp, expHit;

    debug_step_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .BP_BITS         (BPB)
    ) dut (
        .sysClk   (sysClk),
        .sysRes   (sysRes),
        .btnStep  (btnStep),
        .btnRun   (btnRun),
        .bpEnable (bpEnable),
        .bpAddr   (bpAddr),
        .pc       (pc),
        .cpuClkEn (cpuClkEn),
        .halted   (halted),
        .bpHit    (bpHit)
    );

    always #5 sysClk = ~sysClk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", nChecks);
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        for (int k = 0; k <= DB + 1; k++) begin
            hS[k] = 1'b0;
            hR[k] = 1'b0;
        end
        lvlS = 0; lvlR = 0; pStep = 0; pRun = 0;
        mMode = MHalt; mBpHit = 0; mMatchPrev = 0;
    endtask

    // Expected outputs for the current cycle, taken mid-cycle.
    task automatic eval_model();
        @(negedge sysClk);
        mMatch  = bpEnable && (pc[31:16] == bpAddr);
        expHit  = mMatch && !mMatchPrev;
        expEn   = (mMode == MStep) || (mMode == MRun && !expHit);
        expHalt = (mMode == MHalt);
        expBp   = mBpHit;
    endtask

    // Cross one clock edge and update the model; pc advances when the CPU was enabled.
    task automatic advance();
        bit rs, rr, en, flip;
        rs = btnStep; rr = btnRun; en = expEn;
        @(posedge sysClk);
        case (mMode)
            MHalt: begin
                if (pRun) begin
                    mMode = MRun; mBpHit = 0;
                end else if (pStep) begin
                    mMode = MStep;
                end
            end
            MStep: mMode = MHalt;
            default: begin
                if (expHit) begin
                    mMode = MHalt; mBpHit = 1;
                end else if (pRun) begin
                    mMode = MHalt;
                end
            end
        endcase
        mMatchPrev = mMatch;
        for (int k = DB + 1; k > 0; k--) begin
            hS[k] = hS[k-1];
            hR[k] = hR[k-1];
        end
        hS[0] = rs;
        hR[0] = rr;
        // A level is accepted once the synced samples (2 edges old) disagree DB times running.
        flip = 1;
        for (int k = 2; k <= DB + 1; k++) if (hS[k] == lvlS) flip = 0;
        pStep = flip && !lvlS;
        if (flip) lvlS = !lvlS;
        flip = 1;
        for (int k = 2; k <= DB + 1; k++) if (hR[k] == lvlR) flip = 0;
        pRun = flip && !lvlR;
        if (flip) lvlR = !lvlR;
        #1;
        if (en) pc = pc + 32'd1;
    endtask

    task automatic test_reset();
        nChecks++;
        if (halted !== 1'b1 || cpuClkEn !== 1'b0 || bpHit !== 1'b0) begin
            nFails++;
            $display("FAIL reset_values: halted/cpuClkEn/bpHit = %b%b%b, expected 100",
                     halted, cpuClkEn, bpHit);
        end
        for (int c = 0; c < 100; c++) begin
            eval_model();
            nChecks++;
            if (halted !== 1'b1 || cpuClkEn !== 1'b0) begin
                nFails++;
                $display("FAIL idle_after_reset cyc %0d: halted=%b cpuClkEn=%b, expected 1 0",
                         c, halted, cpuClkEn);
            end
            advance();
        end
    endtask

    task automatic test_step_hold();
        int pulses = 0;
        int firstAt = -1;
        btnStep = 1;
        for (int c = 0; c < 32; c++) begin
            if (c == 20) btnStep = 0;
            eval_model();
            nChecks++;
            if (cpuClkEn !== expEn || halted !== expHalt || bpHit !== expBp) begin
                nFails++;
                $display("FAIL step_hold cyc %0d: en/halted/bpHit = %b%b%b, expected %b%b%b",
                         c, cpuClkEn, halted, bpHit, expEn, expHalt, expBp);
            end
            if (firstAt >= 0 && c == firstAt + 1) begin
                nChecks++;
                if (halted !== 1'b1) begin
                    nFails++;
                    $display("FAIL step_rehalt: halted=%b, expected 1", halted);
                end
            end
            if (cpuClkEn === 1'b1) begin
                pulses++;
                if (firstAt < 0) firstAt = c;
            end
            advance();
        end
        nChecks++;
        if (pulses != 1) begin
            nFails++;
            $display("FAIL step_pulse_count: got %0d, expected 1", pulses);
        end
        // Debounced pulse lands 2+DB cycles after the press; STEP is entered one cycle later.
        nChecks++;
        if (firstAt != 2 + DB + 1) begin
            nFails++;
            $display("FAIL step_latency: got %0d, expected %0d", firstAt, 2 + DB + 1);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int c = 0; c < 40; c++) begin
            btnStep = (c < 30) ? 1'((c / 2) % 2 == 0) : 1'b0;
            eval_model();
            nChecks++;
            if (cpuClkEn !== expEn || halted !== expHalt) begin
                nFails++;
                $display("FAIL bounce cyc %0d: en/halted = %b%b, expected %b%b",
                         c, cpuClkEn, halted, expEn, expHalt);
            end
            if (cpuClkEn === 1'b1) pulses++;
            advance();
        end
        nChecks++;
        if (pulses != 0) begin
            nFails++;
            $display("FAIL bounce_pulses: got %0d, expected 0", pulses);
        end
    endtask

    task automatic test_breakpoint();
        bit sawRun = 0;
        bit hitSeen = 0;
        pc = 32'h0000_FFF0;
        bpEnable = 1;
        bpAddr = 16'h0001;
        btnRun = 1;
        for (int c = 0; c < 60; c++) begin
            if (c == 6) btnRun = 0;
            eval_model();
            nChecks++;
            if (cpuClkEn !== expEn || halted !== expHalt || bpHit !== expBp) begin
                nFails++;
                $display("FAIL breakpoint cyc %0d pc %h: en/halted/bpHit = %b%b%b, expected %b%b%b",
                         c, pc, cpuClkEn, halted, bpHit, expEn, expHalt, expBp);
            end
            if (halted === 1'b0) sawRun = 1;
            if (halted === 1'b0 && pc == 32'h0001_0000 && !hitSeen) begin
                hitSeen = 1;
                nChecks++;
                if (cpuClkEn !== 1'b0) begin
                    nFails++;
                    $display("FAIL bp_hit_cycle_enable: cpuClkEn=%b, expected 0", cpuClkEn);
                end
            end
            advance();
        end
        nChecks++;
        if (!sawRun || !hitSeen || halted !== 1'b1 || bpHit !== 1'b1 || pc != 32'h0001_0000) begin
            nFails++;
            $display("FAIL bp_final: run=%0d hit=%0d halted=%b bpHit=%b pc=%h, expected 1 1 1 1 00010000",
                     sawRun, hitSeen, halted, bpHit, pc);
        end
    endtask

    task automatic test_resume();
        bit sawRun = 0;
        bit reHalt = 0;
        btnRun = 1;
        for (int c = 0; c < 40; c++) begin
            if (c == 6) btnRun = 0;
            eval_model();
            nChecks++;
            if (cpuClkEn !== expEn || halted !== expHalt || bpHit !== expBp) begin
                nFails++;
                $display("FAIL resume cyc %0d: en/halted/bpHit = %b%b%b, expected %b%b%b",
                         c, cpuClkEn, halted, bpHit, expEn, expHalt, expBp);
            end
            if (sawRun && halted === 1'b1) reHalt = 1;
            if (halted === 1'b0) sawRun = 1;
            advance();
        end
        nChecks++;
        if (!sawRun || reHalt || bpHit !== 1'b0 || pc[31:16] != 16'h0001) begin
            nFails++;
            $display("FAIL resume_state: run=%0d rehalt=%0d bpHit=%b pc=%h, expected 1 0 0 0001xxxx",
                     sawRun, reHalt, bpHit, pc);
        end
        btnRun = 1;
        for (int c = 0; c < 20; c++) begin
            if (c == 6) btnRun = 0;
            eval_model();
            nChecks++;
            if (cpuClkEn !== expEn || halted !== expHalt || bpHit !== expBp) begin
                nFails++;
                $display("FAIL run_halt cyc %0d: en/halted/bpHit = %b%b%b, expected %b%b%b",
                         c, cpuClkEn, halted, bpHit, expEn, expHalt, expBp);
            end
            advance();
        end
        nChecks++;
        if (halted !== 1'b1 || bpHit !== 1'b0) begin
            nFails++;
            $display("FAIL run_halt_final: halted=%b bpHit=%b, expected 1 0", halted, bpHit);
        end
    endtask

    task automatic press_and_count(input int holdCycles, input int expPulses, input string name);
        int pulses = 0;
        btnStep = 1;
        for (int c = 0; c < holdCycles + 15; c++) begin
            if (c == holdCycles) btnStep = 0;
            eval_model();
            nChecks++;
            if (cpuClkEn !== expEn || halted !== expHalt) begin
                nFails++;
                $display("FAIL %s cyc %0d: en/halted = %b%b, expected %b%b",
                         name, c, cpuClkEn, halted, expEn, expHalt);
            end
            if (cpuClkEn === 1'b1) pulses++;
            advance();
        end
        nChecks++;
        if (pulses != expPulses) begin
            nFails++;
            $display("FAIL %s_pulses: got %0d, expected %0d", name, pulses, expPulses);
        end
    endtask

    task automatic test_async_reset();
        bpEnable = 0;
        btnRun = 1;
        for (int c = 0; c < 14; c++) begin
            if (c == 6) btnRun = 0;
            if (c == 12) btnStep = 1;
            eval_model();
            advance();
        end
        eval_model();
        nChecks++;
        if (halted !== 1'b0 || cpuClkEn !== 1'b1) begin
            nFails++;
            $display("FAIL pre_reset_run: halted=%b cpuClkEn=%b, expected 0 1", halted, cpuClkEn);
        end
        #2 sysRes = 1;
        #1;
        nChecks++;
        if (cpuClkEn !== 1'b0 || halted !== 1'b1 || bpHit !== 1'b0) begin
            nFails++;
            $display("FAIL async_reset: en/halted/bpHit = %b%b%b, expected 010",
                     cpuClkEn, halted, bpHit);
        end
        model_reset();
        btnStep = 0;
        @(posedge sysClk);
        @(posedge sysClk);
        #1 sysRes = 0;
        press_and_count(3, 0, "partial_press");
        press_and_count(DB, 1, "full_press");
    endtask

    task automatic test_random();
        int hsL = 0;
        int hrL = 0;
        bpEnable = 1;
        bpAddr = 16'h0001;
        for (int c = 0; c < 3000; c++) begin
            if (hsL == 0) begin
                btnStep = ($urandom_range(0, 2) == 0);
                hsL = $urandom_range(1, 12);
            end
            hsL--;
            if (hrL == 0) begin
                btnRun = ($urandom_range(0, 4) == 0);
                hrL = $urandom_range(1, 14);
            end
            hrL--;
            if ($urandom_range(0, 199) == 0) bpEnable = !bpEnable;
            if ($urandom_range(0, 299) == 0) bpAddr = 16'($urandom_range(0, 1));
            if (mMode == MHalt && $urandom_range(0, 40) == 0)
                pc = {16'($urandom_range(0, 1)), 16'hFFF0 | 16'($urandom_range(0, 15))};
            eval_model();
            nChecks++;
            if (cpuClkEn !== expEn || halted !== expHalt || bpHit !== expBp) begin
                nFails++;
                $display("FAIL random cyc %0d pc %h: en/halted/bpHit = %b%b%b, expected %b%b%b",
                         c, pc, cpuClkEn, halted, bpHit, expEn, expHalt, expBp);
            end
            advance();
        end
    endtask

    initial begin
        sysRes = 1; btnStep = 0; btnRun = 0; bpEnable = 0; bpAddr = '0; pc = '0;
        model_reset();
        repeat (3) @(posedge sysClk);
        #1 sysRes = 0;
        test_reset();
        test_step_hold();
        test_bounce();
        test_breakpoint();
        test_resume();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
